// File: rtl/booth_mult_seq_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the KGP-RISC ALU Booth multiplier slice.
//   DEF_WIDTH  : default operand width (product is twice this)
//   DEF_CNT_W  : default iteration-counter width (2**DEF_CNT_W > DEF_WIDTH)
//   state_t    : multiplier FSM states IDLE / RUN / DONE
//   BOOTH_ADD  : {Q[0],Q_1} pattern that adds the multiplicand
//   BOOTH_SUB  : {Q[0],Q_1} pattern that adds the negated multiplicand
// ---------------------------------------------------------------------------
package alu_pkg;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_CNT_W = 6;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

   localparam logic [1:0] BOOTH_ADD = 2'b01;
   localparam logic [1:0] BOOTH_SUB = 2'b10;

endpackage

// File: rtl/booth_mult_seq_step.sv
// ---------------------------------------------------------------------------
// booth_step
// One combinational radix-2 Booth iteration: conditional add/subtract of the
// multiplicand into the accumulator, then a one-bit arithmetic shift right of
// the combined {A,Q,Q_1} register.
//   i_a    [WIDTH:0]   accumulator A (one guard bit wide)
//   i_q    [WIDTH-1:0] multiplier register Q
//   i_q1               previous Q[0] (Q_1)
//   i_m    [WIDTH:0]   sign-extended multiplicand M
//   i_negM [WIDTH:0]   two's complement of M
//   o_a, o_q, o_q1     register values after this step
// ---------------------------------------------------------------------------
module booth_step
   import alu_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic [WIDTH:0]   i_a,
   input  logic [WIDTH-1:0] i_q,
   input  logic             i_q1,
   input  logic [WIDTH:0]   i_m,
   input  logic [WIDTH:0]   i_negM,
   output logic [WIDTH:0]   o_a,
   output logic [WIDTH-1:0] o_q,
   output logic             o_q1
);

   logic [WIDTH:0] w_sum;

   // Booth recoding of the pair {Q[0],Q_1}: 01 adds M, 10 subtracts M by
   // adding the pre-negated copy, 00 and 11 leave the accumulator alone.
   always_comb begin
      w_sum = i_a;
      case ({i_q[0], i_q1})
         BOOTH_ADD: w_sum = i_a + i_m;
         BOOTH_SUB: w_sum = i_a + i_negM;
         default:   w_sum = i_a;
      endcase
   end

   // Arithmetic shift right of {A,Q,Q_1}: A's sign bit is replicated, the bit
   // falling out of A enters the top of Q, and Q[0] becomes the new Q_1.
   assign o_a  = {w_sum[WIDTH], w_sum[WIDTH:1]};
   assign o_q  = {w_sum[0], i_q[WIDTH-1:1]};
   assign o_q1 = i_q[0];

endmodule

// File: rtl/booth_mult_seq.sv
// ---------------------------------------------------------------------------
// booth_mult_seq
// Sequential radix-2 Booth multiplier: signed WIDTH x WIDTH -> 2*WIDTH product
// in WIDTH iterations, with a start/busy/done handshake.
//   clk          : rising-edge clock
//   rst          : asynchronous, active-low reset
//   start        : request; operands are captured when accepted (IDLE/DONE)
//   multiplicand : signed operand M
//   multiplier   : signed operand Q
//   busy         : high while iterations run
//   done         : one-cycle pulse when product is valid
//   product      : registered signed result, held until the next completion
// ---------------------------------------------------------------------------
module booth_mult_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [WIDTH-1:0]   multiplicand,
   input  logic [WIDTH-1:0]   multiplier,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   state_t             r_state;
   state_t             w_nextState;
   logic               r_busy;
   logic               r_done;
   logic               w_nextBusy;
   logic               w_nextDone;
   logic [WIDTH:0]     r_a;
   logic [WIDTH-1:0]   r_q;
   logic               r_q1;
   logic [WIDTH:0]     r_m;
   logic [WIDTH:0]     r_negM;
   logic [CNT_W-1:0]   r_count;
   logic [2*WIDTH-1:0] r_product;

   logic [WIDTH:0]     w_mExt;
   logic [WIDTH:0]     w_negM;
   logic               w_accept;
   logic               w_lastStep;
   logic [WIDTH:0]     w_stepA;
   logic [WIDTH-1:0]   w_stepQ;
   logic               w_stepQ1;

   // The accumulator carries one guard bit so that negating the most
   // negative multiplicand cannot overflow; negM is formed once at load with
   // the usual invert-and-increment path and reused on every subtract step.
   assign w_mExt     = {multiplicand[WIDTH-1], multiplicand};
   assign w_negM     = ~w_mExt + {{WIDTH{1'b0}}, 1'b1};
   assign w_accept   = start && ((r_state == IDLE) || (r_state == DONE));
   assign w_lastStep = (r_state == RUN) && (r_count == CNT_W'(WIDTH - 1));

   booth_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .i_a    (r_a),
      .i_q    (r_q),
      .i_q1   (r_q1),
      .i_m    (r_m),
      .i_negM (r_negM),
      .o_a    (w_stepA),
      .o_q    (w_stepQ),
      .o_q1   (w_stepQ1)
   );

   // State register together with the registered busy/done flags, so the
   // handshake outputs never see a combinational path from the inputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_nextState;
         r_busy  <= w_nextBusy;
         r_done  <= w_nextDone;
      end
   end

   // Next-state logic: a start in DONE is accepted straight back into RUN,
   // while a start seen during RUN is ignored. busy/done are decoded from the
   // state being entered so they line up with it after the edge.
   always_comb begin
      w_nextState = r_state;
      w_nextBusy  = 1'b0;
      w_nextDone  = 1'b0;
      case (r_state)
         IDLE: if (start) w_nextState = RUN;
         RUN:  if (w_lastStep) w_nextState = DONE;
         DONE: w_nextState = start ? RUN : IDLE;
         default: w_nextState = IDLE;
      endcase
      w_nextBusy = (w_nextState == RUN);
      w_nextDone = (w_nextState == DONE);
   end

   // Datapath: load operands on acceptance, otherwise run one Booth step per
   // cycle while in RUN. The product register is written only on the final
   // step, from the post-shift values, and otherwise holds its last result.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_a       <= '0;
         r_q       <= '0;
         r_q1      <= 1'b0;
         r_m       <= '0;
         r_negM    <= '0;
         r_count   <= '0;
         r_product <= '0;
      end else if (w_accept) begin
         r_a     <= '0;
         r_q     <= multiplier;
         r_q1    <= 1'b0;
         r_m     <= w_mExt;
         r_negM  <= w_negM;
         r_count <= '0;
      end else if (r_state == RUN) begin
         r_a     <= w_stepA;
         r_q     <= w_stepQ;
         r_q1    <= w_stepQ1;
         r_count <= r_count + CNT_W'(1);
         if (w_lastStep) begin
            r_product <= {w_stepA[WIDTH-1:0], w_stepQ};
         end
      end
   end

   assign busy    = r_busy;
   assign done    = r_done;
   assign product = r_product;

endmodule

// File: doc/booth_mult_seq.md
Name: booth_mult_seq

Overview:
Sequential radix-2 Booth multiplier for the KGP-RISC ALU. It produces the signed 64-bit product of two 32-bit operands over 32 cycles using a start/busy/done handshake. It sits downstream of the two's-complement negate stage: the negated multiplicand is captured once at start and reused on every subtract step. The 64-bit result is consumed by the register-write stage.

Parameters:
WIDTH, 32, operand width in bits; product is 2*WIDTH.
CNT_W, 6, iteration-counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clk  input  1  system clock, rising-edge.
rst  input  1  asynchronous, active-low reset.
start  input  1  request pulse; operands sampled when accepted.
multiplicand  input  WIDTH  signed operand M.
multiplier  input  WIDTH  signed operand Q.
busy  output  1  high while iterations run.
done  output  1  one-cycle pulse when product is valid.
product  output  2*WIDTH  signed result, registered.

Behaviour:
- Reset (rst=0, async): state=IDLE, busy=0, done=0, product=0, internal A/Q/Q_1/M/negM/count=0. Reset asserted mid-operation aborts the operation; no done pulse follows.
- States: IDLE, RUN, DONE.
- IDLE: start=1 at edge e0 -> load the following, then go to RUN:
  - A=0 (WIDTH+1 bits), Q=multiplier, Q_1=0.
  - M=sign-extend(multiplicand) to WIDTH+1 bits; negM=two's complement of M, also WIDTH+1 bits.
  - count=0.
- RUN: one Booth step per edge:
  - {Q[0],Q_1}=01 -> A=A+M.
  - 10 -> A=A+negM.
  - 00/11 -> A unchanged.
  - Then arithmetic shift right of {A,Q,Q_1} by 1, with A's MSB replicated.
  - count++. On the step where count==WIDTH-1 (the 32nd step, edge e32): product={A[WIDTH-1:0],Q} taken from the post-shift values, state=DONE.
- DONE: done=1 and busy=0 for exactly one cycle (between e32 and e33). Next state is IDLE, or RUN if start=1 (back-to-back accepted).
- busy=1 exactly in RUN (e0..e32 window, i.e. 32 cycles). Outputs are registered; no combinational path from inputs to outputs.
- Latency: done is visible 32 cycles after the accepting edge. Throughput is one product per 33 cycles; back-to-back start in DONE also gives 33.
- start while in RUN is ignored. Operand changes during RUN have no effect, because operands are captured.
- product holds its value until the next completion. It does not change on start, abort or reset-deassert; it is cleared only by reset.
- Width rule: the accumulator is WIDTH+1 bits so that M=-2^(WIDTH-1) negates without overflow. The full product is exact for all inputs, including -2^31 * -2^31 = +2^62.
- Simultaneous start with reset: reset dominates.

Decomposition:
- Shared package (alu_pkg):
  - state encoding constants IDLE=2'b00, RUN=2'b01, DONE=2'b10;
  - WIDTH default;
  - Booth code constants BOOTH_ADD=2'b01, BOOTH_SUB=2'b10.
- One combinational sub-module, booth_step: inputs A, Q, Q_1, M, negM; outputs next A, Q and Q_1 (add/sub select plus arithmetic shift).
- The top holds the FSM, counter and registers. negM is computed at load using the existing NOT+ADDER negate path or an equivalent.

Test Plan:
- 3 * 5: start 1 cycle -> busy for 32 cycles; done pulse at cycle 32; product=64'h0000_0000_0000_000F.
- -7 * 6 (0xFFFFFFF9, 0x00000006) -> product=64'hFFFF_FFFF_FFFF_FFD6. Also -1 * -1 (0xFFFFFFFF twice) -> 64'h0000_0000_0000_0001.
- 0x80000000 * 0x80000000 -> 64'h4000_0000_0000_0000. Then 0x80000000 * 0x7FFFFFFF -> 64'hC000_0000_8000_0000.
- Operands 12 * 12, with start re-pulsed and operands changed to 99/99 at cycle 10 of RUN -> second start ignored; product=144; exactly one done pulse.
- Assert rst=0 at cycle 15 of RUN -> busy=0, done=0, product=0 immediately (async). After release, no done pulse; a new start 2*3 gives 6.
- Back-to-back: start with 2*3, then start held high during the DONE cycle with 4*5 -> done at cycle 32 with product 6; busy again next cycle; done 33 cycles later with product 20.
